stream_mux_n_1: RTL and testbench

Parametrised N-channel, W-bit streaming N:1 multiplexer with a valid/ready handshake on every channel, one registered output stage, and packet-aware channel locking. A select mode gives the legacy fixed-`sel` behaviour; a round-robin mode arbitrates fairly between channels. It sits between several producer streams and a single consumer, for example a shared bus port or output FIFO.

---
 rtl/stream_mux_n_1_pkg.sv | 15 +
 rtl/stream_mux_n_1_if.sv | 32 +++
 rtl/stream_mux_n_1_rr_arbiter.sv | 26 ++
 rtl/stream_mux_n_1.sv | 134 +++++++++++++
 tb/tb_stream_mux_n_1.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/stream_mux_n_1_pkg.sv
// Shared types and helpers for the N:1 stream multiplexer.
package stream_mux_pkg;

    // IDLE: free to pick a channel; LOCK: a packet is in progress on lock_chan.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Increment a channel index with wrap at n (works for non-power-of-2 n).
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/stream_mux_n_1_if.sv
// Bundle of the N producer channels and the single consumer channel.
//
// Handshake: on every channel a beat moves at a rising clk edge exactly when
// valid and ready are both 1. valid must not depend on ready, and data/last
// must stay stable while valid=1 and ready=0.
interface stream_mux_n_1_if #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) ();
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [SW-1:0]  out_chan;
    logic           out_valid;
    logic           out_ready;

    // The multiplexer's view.
    modport slave (
        input  in_data, in_last, in_valid, out_ready,
        output in_ready, out_data, out_last, out_chan, out_valid
    );

    // The producers' and consumer's view.
    modport master (
        output in_data, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_last, out_chan, out_valid
    );
endinterface

// File: rtl/stream_mux_n_1_rr_arbiter.sv
// Combinational round-robin search: first requesting channel at or after ptr.
module rr_arbiter_n #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [SW-1:0] i_ptr,
    output logic [SW-1:0] o_gnt,
    output logic          o_gnt_vld
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_gnt     = '0;
        o_gnt_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            int idx;
            idx = (int'(i_ptr) + i) % N;
            if (i_req[idx]) begin
                o_gnt     = SW'(idx);
                o_gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_n_1.sv
// N:1 stream multiplexer with a registered output stage, fixed-select or
// round-robin arbitration, and packet locking so packets never interleave.
module stream_mux_n_1
    import stream_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [SW-1:0]     sel,
    stream_mux_n_1_if.slave   bus,
    output state_t            o_dbg_state,
    output logic [SW-1:0]     o_dbg_rr_ptr,
    output logic [SW-1:0]     o_dbg_lock_chan
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [SW-1:0]  r_lock_chan;
    logic [SW-1:0]  r_rr_ptr;

    logic [W-1:0]   r_out_data;
    logic           r_out_last;
    logic [SW-1:0]  r_out_chan;
    logic           r_out_valid;

    logic           w_can_load;
    logic [SW-1:0]  w_g;
    logic           w_grant_vld;
    logic [SW-1:0]  w_arb_gnt;
    logic           w_arb_vld;
    logic           w_accept;
    logic [W-1:0]   w_beat_data;
    logic           w_beat_last;
    logic [N-1:0]   w_in_ready;

    rr_arbiter_n #(.N(N), .SW(SW)) u_arb (
        .i_req     (bus.in_valid),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_arb_gnt),
        .o_gnt_vld (w_arb_vld)
    );

    // Reset holds every ready low; otherwise the output register is free
    // when empty or being drained this cycle.
    assign w_can_load = rst_n && (!r_out_valid || bus.out_ready);

    // Grant selection: locked channel first, then fixed select or round-robin.
    always_comb begin
        w_g         = '0;
        w_grant_vld = 1'b0;
        if (r_state == ST_LOCK) begin
            w_g         = r_lock_chan;
            w_grant_vld = bus.in_valid[r_lock_chan];
        end else if (!mode) begin
            w_g = sel;
            if (int'(sel) < N) begin
                w_grant_vld = bus.in_valid[sel];
            end
        end else begin
            w_g         = w_arb_gnt;
            w_grant_vld = w_arb_vld;
        end
    end

    assign w_accept    = w_can_load && w_grant_vld;
    assign w_beat_data = bus.in_data[int'(w_g)*W +: W];
    assign w_beat_last = bus.in_last[w_g];

    // One-hot ready toward the granted channel only.
    always_comb begin
        w_in_ready = '0;
        if (w_accept) begin
            w_in_ready[w_g] = 1'b1;
        end
    end

    // Next-state logic: lock on a non-final beat, release on the final beat.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && !w_beat_last) w_state_nxt = ST_LOCK;
            ST_LOCK: if (w_accept &&  w_beat_last) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, lock channel and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_lock_chan <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && r_state == ST_IDLE) begin
                r_lock_chan <= w_g;
            end
            if (w_accept && w_beat_last && mode) begin
                r_rr_ptr <= SW'(next_idx(int'(w_g), N));
            end
        end
    end

    // Output register: load on acceptance, drop valid when drained.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_chan  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_beat_data;
            r_out_last  <= w_beat_last;
            r_out_chan  <= w_g;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_data      = r_out_data;
    assign bus.out_last      = r_out_last;
    assign bus.out_chan      = r_out_chan;
    assign bus.out_valid     = r_out_valid;
    assign o_dbg_state       = r_state;
    assign o_dbg_rr_ptr      = r_rr_ptr;
    assign o_dbg_lock_chan   = r_lock_chan;

endmodule

// File: tb/tb_stream_mux_n_1.sv
// Directed bench for stream_mux_n_1: a 4-channel and a 3-channel instance.
module tb_stream_mux_n_1;
    import stream_mux_pkg::*;

    logic clk;
    logic rst_n;

    logic       mode4;
    logic [1:0] sel4;
    logic       mode3;
    logic [1:0] sel3;

    state_t     st4, st3;
    logic [1:0] rr4, rr3, lk4, lk3;

    stream_mux_n_1_if #(.N(4), .W(8)) bus4 ();
    stream_mux_n_1_if #(.N(3), .W(8)) bus3 ();

    stream_mux_n_1 #(.N(4), .W(8)) dut4 (
        .clk (clk), .rst_n (rst_n), .mode (mode4), .sel (sel4), .bus (bus4.slave),
        .o_dbg_state (st4), .o_dbg_rr_ptr (rr4), .o_dbg_lock_chan (lk4)
    );

    stream_mux_n_1 #(.N(3), .W(8)) dut3 (
        .clk (clk), .rst_n (rst_n), .mode (mode3), .sel (sel3), .bus (bus3.slave),
        .o_dbg_state (st3), .o_dbg_rr_ptr (rr3), .o_dbg_lock_chan (lk3)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d);
        bus4.in_valid = v;
        bus4.in_last  = l;
        bus4.in_data  = d;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        mode4 = 1'b0; sel4 = 2'd0; mode3 = 1'b0; sel3 = 2'd0;
        bus4.in_valid = '1; bus4.in_last = '1; bus4.in_data = 32'hA3A2A1A0; bus4.out_ready = 1'b1;
        bus3.in_valid = '0; bus3.in_last = '0; bus3.in_data = '0;           bus3.out_ready = 1'b1;

        // Reset values, with all channels valid during reset.
        tick(); tick();
        check("rst_in_ready", 32'(bus4.in_ready), 32'h0);
        check("rst_out_valid", 32'(bus4.out_valid), 32'h0);
        check("rst_out_data", 32'(bus4.out_data), 32'h0);
        check("rst_out_chan", 32'(bus4.out_chan), 32'h0);
        check("rst_state", 32'(st4), 32'(ST_IDLE));
        check("rst_rr_ptr", 32'(rr4), 32'h0);

        // Fixed mode, sel=2, one-beat packets.
        rst_n = 1'b1;
        sel4  = 2'd2;
        drive4(4'b1111, 4'b1111, 32'hA3A5A1A0);
        for (int i = 0; i < 3; i++) begin
            check("fix_in_ready", 32'(bus4.in_ready), 32'h4);
            tick();
            check("fix_out_valid", 32'(bus4.out_valid), 32'h1);
            check("fix_out_data", 32'(bus4.out_data), 32'hA5);
            check("fix_out_chan", 32'(bus4.out_chan), 32'h2);
        end
        check("fix_rr_untouched", 32'(rr4), 32'h0);

        // Round-robin fairness with all channels valid.
        mode4 = 1'b1;
        drive4(4'b1111, 4'b1111, 32'h13121110);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(32'(i % 4));
            check("rr_in_ready", 32'(bus4.in_ready), 32'(1 << (i % 4)));
            tick();
            check("rr_out_chan", 32'(bus4.out_chan), exp_q.pop_front());
            check("rr_out_data", 32'(bus4.out_data), 32'h10 + 32'(i % 4));
        end

        // Move rr_ptr to 1 with a lone channel-0 beat.
        drive4(4'b0001, 4'b1111, 32'h000000C0);
        tick();
        check("lk_pre_ptr", 32'(rr4), 32'h1);

        // Packet lock: 3-beat packet on ch1 while ch0 and ch3 compete.
        drive4(4'b1011, 4'b1101, 32'hD3003100);
        check("lk_b1_ready", 32'(bus4.in_ready), 32'h2);
        tick();
        check("lk_b1_chan", 32'(bus4.out_chan), 32'h1);
        check("lk_b1_data", 32'(bus4.out_data), 32'h31);
        check("lk_state", 32'(st4), 32'(ST_LOCK));
        drive4(4'b1011, 4'b1101, 32'hD3003200);
        check("lk_b2_ready", 32'(bus4.in_ready), 32'h2);
        tick();
        check("lk_b2_data", 32'(bus4.out_data), 32'h32);
        drive4(4'b1011, 4'b1111, 32'hD3003300);
        tick();
        check("lk_b3_data", 32'(bus4.out_data), 32'h33);
        check("lk_b3_last", 32'(bus4.out_last), 32'h1);
        check("lk_release", 32'(st4), 32'(ST_IDLE));
        check("lk_ptr", 32'(rr4), 32'h2);
        drive4(4'b1001, 4'b1111, 32'hD30000D0);
        tick();
        check("lk_next3", 32'(bus4.out_chan), 32'h3);
        check("lk_next3_data", 32'(bus4.out_data), 32'hD3);
        tick();
        check("lk_next0", 32'(bus4.out_chan), 32'h0);
        check("lk_next0_data", 32'(bus4.out_data), 32'hD0);

        // Backpressure: ch2 alone, output stalls for three cycles.
        drive4(4'b0100, 4'b1111, 32'h00770000);
        tick();
        check("bp_first", 32'(bus4.out_data), 32'h77);
        bus4.out_ready = 1'b0;
        drive4(4'b0100, 4'b1111, 32'h00880000);
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", 32'(bus4.in_ready), 32'h0);
            tick();
            check("bp_hold_data", 32'(bus4.out_data), 32'h77);
            check("bp_hold_valid", 32'(bus4.out_valid), 32'h1);
        end
        bus4.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus4.in_ready), 32'h4);
        tick();
        check("bp_next", 32'(bus4.out_data), 32'h88);
        drive4(4'b0000, 4'b1111, 32'h0);
        tick();
        check("bp_drain_valid", 32'(bus4.out_valid), 32'h0);
        check("bp_drain_data", 32'(bus4.out_data), 32'h88);
        check("bp_ptr", 32'(rr4), 32'h3);

        // Reset mid-packet: two beats of a 4-beat packet on ch3.
        drive4(4'b1000, 4'b0000, 32'h41000000);
        tick();
        drive4(4'b1000, 4'b0000, 32'h42000000);
        tick();
        check("mr_locked", 32'(st4), 32'(ST_LOCK));
        check("mr_lock_chan", 32'(lk4), 32'h3);
        rst_n = 1'b0;
        drive4(4'b1010, 4'b0010, 32'h43002100);
        check("mr_rst_ready", 32'(bus4.in_ready), 32'h0);
        tick();
        check("mr_out_valid", 32'(bus4.out_valid), 32'h0);
        check("mr_state", 32'(st4), 32'(ST_IDLE));
        rst_n = 1'b1;
        #1;
        check("mr_grant_ready", 32'(bus4.in_ready), 32'h2);
        tick();
        check("mr_grant_chan", 32'(bus4.out_chan), 32'h1);
        check("mr_grant_data", 32'(bus4.out_data), 32'h21);
        drive4(4'b0000, 4'b1111, 32'h0);

        // N=3: out-of-range select never grants.
        mode3 = 1'b0; sel3 = 2'd3;
        bus3.in_valid = 3'b111; bus3.in_last = 3'b111; bus3.in_data = 24'h5C5B5A;
        #1;
        check("n3_sel3_ready", 32'(bus3.in_ready), 32'h0);
        tick(); tick();
        check("n3_sel3_valid", 32'(bus3.out_valid), 32'h0);

        // N=3 round-robin wrap: ch1 -> ptr 2, ch2 -> ptr wraps to 0.
        mode3 = 1'b1;
        bus3.in_valid = 3'b010;
        tick();
        check("n3_ch1_chan", 32'(bus3.out_chan), 32'h1);
        check("n3_ptr2", 32'(rr3), 32'h2);
        bus3.in_valid = 3'b100;
        #1;
        check("n3_ch2_ready", 32'(bus3.in_ready), 32'h4);
        tick();
        check("n3_ch2_chan", 32'(bus3.out_chan), 32'h2);
        check("n3_ch2_data", 32'(bus3.out_data), 32'h5C);
        check("n3_ptr_wrap", 32'(rr3), 32'h0);
        bus3.in_valid = 3'b111;
        #1;
        check("n3_after_wrap", 32'(bus3.in_ready), 32'h1);
        tick();
        check("n3_after_chan", 32'(bus3.out_chan), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
